// File: rtl/mult_share_pkg.sv
// mult_share_pkg: FSM state type, default parameters and index-width helper
// shared by the mult_share_arbiter RTL and its interface.
package mult_share_pkg;

    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: requester operand bus and result bus of the shared multiplier.
interface mult_share_arbiter_if
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) ();

    localparam int IDW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [2*WIDTH-1:0]       rsp_product;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at last_grant+1, wrapping to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any
);

    logic [IDW-1:0] j;

    // Scan from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        grant_idx = '0;
        j = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (req[j]) grant_idx = j;
        end
    end

    assign any   = |req;
    assign grant = any ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin shared unsigned multiplier (IDLE/MUL/RESP).
// Define MULT_SHARE_ARB_FAST_EN to skip MUL and multiply combinationally at grant.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input logic clk,
    input logic rst_n,
    mult_share_arbiter_if.slave bus
);

    localparam int IDW = idx_w(NUM_REQ);
    localparam int PW  = 2 * WIDTH;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     gidx;
    logic               any;
    logic [WIDTH-1:0]   a_sel, b_sel;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (gidx),
        .any        (any)
    );

    assign a_sel = bus.req_a[gidx*WIDTH +: WIDTH];
    assign b_sel = bus.req_b[gidx*WIDTH +: WIDTH];

`ifdef MULT_SHARE_ARB_FAST_EN

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        rsp_id_d = rsp_id_q;
        prod_d   = prod_q;
        case (state_q)
            IDLE: if (any) begin
                state_d  = RESP;
                last_d   = gidx;
                rsp_id_d = gidx;
                prod_d   = PW'(a_sel) * PW'(b_sel);
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`else

    localparam int CW = idx_w(WIDTH);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;

    assign last_bit = cnt_q == CW'(WIDTH - 1);

    // Operands and owner are latched at grant so later bus changes cannot leak in.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        id_d  = id_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (state_q == IDLE && any) begin
            a_d   = a_sel;
            b_d   = b_sel;
            id_d  = gidx;
            cnt_d = '0;
            acc_d = '0;
        end else if (state_q == MUL) begin
            acc_d = acc_q + (b_q[cnt_q] ? (PW'(a_q) << cnt_q) : PW'(0));
            cnt_d = last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            id_q  <= id_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        rsp_id_d = rsp_id_q;
        prod_d   = prod_q;
        case (state_q)
            IDLE: if (any) begin
                state_d = MUL;
                last_d  = gidx;
            end
            MUL: if (last_bit) begin
                state_d  = RESP;
                rsp_id_d = id_q;
                prod_d   = acc_d;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= IDW'(NUM_REQ - 1);
            rsp_id_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rsp_id_q <= rsp_id_d;
            prod_q   <= prod_d;
        end
    end

    // Gated by rst_n so no requester sees an accept while reset is held.
    assign bus.req_ready   = (rst_n && state_q == IDLE) ? grant : '0;
    assign bus.rsp_valid   = state_q == RESP;
    assign bus.busy        = state_q != IDLE;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = prod_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed plus randomized checks of mult_share_arbiter
// against a transaction-level model of grants, latency and products.
module tb_mult_share_arbiter;
    import mult_share_pkg::*;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int PW = 2 * W;
`ifdef MULT_SHARE_ARB_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = W + 1;
`endif
    localparam bit FAST = (LAT == 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    mult_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // model: 0 idle, 1 computing (m_left edges to go), 2 holding a response
    int m_phase = 0;
    int m_left = 0;
    int m_last = N - 1;
    int m_pid = 0;
    int m_oid = 0;
    logic [PW-1:0] m_pprod = '0;
    logic [PW-1:0] m_oprod = '0;

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [PW-1:0] prod_of(input int i);
        logic [W-1:0] a, b;
        a = bus.req_a[i*W +: W];
        b = bus.req_b[i*W +: W];
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        w = pick(bus.req_valid, m_last);
        return (rst_n && m_phase == 0 && w >= 0) ? (N'(1) << w) : '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_last  <= N - 1;
            m_oid   <= 0;
            m_oprod <= '0;
        end else if (m_phase == 0) begin
            if (pick(bus.req_valid, m_last) >= 0) begin
                m_last  <= pick(bus.req_valid, m_last);
                m_pid   <= pick(bus.req_valid, m_last);
                m_pprod <= prod_of(pick(bus.req_valid, m_last));
                m_left  <= W;
                m_phase <= FAST ? 2 : 1;
                if (FAST) begin
                    m_oid   <= pick(bus.req_valid, m_last);
                    m_oprod <= prod_of(pick(bus.req_valid, m_last));
                end
            end
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_phase <= 2;
                m_oid   <= m_pid;
                m_oprod <= m_pprod;
            end
        end else if (bus.rsp_ready) begin
            m_phase <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_req_ready", 32'(bus.req_ready), 32'(exp_ready()));
        chk("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(m_phase == 2));
        chk("cyc_busy", 32'(bus.busy), 32'(m_phase != 0));
        chk("cyc_rsp_id", 32'(bus.rsp_id), 32'(m_oid));
        chk("cyc_rsp_product", 32'(bus.rsp_product), 32'(m_oprod));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 20) begin
            tick();
            #1;
            n++;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            #1;
            n++;
        end
    endtask

    task automatic do_op(input int i, input int a, input int b, input int exp);
        int n;
        bus.req_valid = N'(1) << i;
        set_op(i, W'(a), W'(b));
        bus.rsp_ready = 1'b1;
        wait_grant(n);
        chk("op_grant", 32'(bus.req_ready), 32'(N'(1) << i));
        wait_rsp(n);
        chk("op_latency", n, LAT);
        chk("op_product", 32'(bus.rsp_product), exp);
        chk("op_id", 32'(bus.rsp_id), i);
        bus.req_valid = '0;
        tick();
    endtask

    int pa[4] = '{3, 7, 11, 15};
    int pb[4] = '{5, 9, 2, 15};
    int pe[4] = '{15, 63, 22, 225};

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        #2;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rsp_product", 32'(bus.rsp_product), 0);
        do_reset();

        do_op(0, 15, 15, 225);
        do_op(0, 0, 7, 0);
        do_op(1, 9, 1, 9);
        do_op(3, 8, 12, 96);
        do_op(2, 13, 11, 143);

        // all four held from reset: order 0,1,2,3,0
        rst_n = 1'b0;
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) set_op(i, W'(pa[i]), W'(pb[i]));
        tick();
        tick();
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(n);
            chk("rr_order", 32'(bus.req_ready), 32'(N'(1) << (g % N)));
            wait_rsp(n);
            chk("rr_product", 32'(bus.rsp_product), pe[g % N]);
            chk("rr_id", 32'(bus.rsp_id), g % N);
        end

        // stall in RESP with operands changed mid-flight
        bus.req_valid = '0;
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        set_op(0, 8, 12);
        wait_grant(n);
        chk("stall_grant", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = '1;
        set_op(0, 9, 1);
        set_op(1, 4'hf, 4'hf);
        #1;
        wait_rsp(n);
        chk("stall_latency", n, LAT - 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            chk("stall_valid", 32'(bus.rsp_valid), 1);
            chk("stall_product", 32'(bus.rsp_product), 96);
            chk("stall_id", 32'(bus.rsp_id), 0);
            chk("stall_ready", 32'(bus.req_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        chk("post_grant", 32'(bus.req_ready), 2);
        chk("post_valid", 32'(bus.rsp_valid), 0);
        chk("post_product", 32'(bus.rsp_product), 96);
        chk("post_id", 32'(bus.rsp_id), 0);
        bus.req_valid = '0;

        // reset while req2 is mid-multiply
        do_reset();
        bus.req_valid = 4'b0100;
        set_op(2, 5, 6);
        wait_grant(n);
        chk("abort_grant", 32'(bus.req_ready), 4);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        bus.req_valid = 4'b0101;
        set_op(0, 3, 4);
        #1;
        chk("abort_ready", 32'(bus.req_ready), 0);
        chk("abort_valid", 32'(bus.rsp_valid), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_id", 32'(bus.rsp_id), 0);
        chk("abort_product", 32'(bus.rsp_product), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_next_grant", 32'(bus.req_ready), 1);
        wait_rsp(n);
        chk("abort_next_id", 32'(bus.rsp_id), 0);
        chk("abort_next_product", 32'(bus.rsp_product), 12);
        bus.req_valid = '0;

        // randomized traffic with backpressure and rare reset pulses
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
            bus.rsp_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; SHALL be >= 2.
REQ-002 Parameter WIDTH, default 4, operand width in bits; product width is 2*WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-007 req_a  input  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NUM_REQ*WIDTH  operand B, same packing as req_a.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  result consumer accept.
REQ-011 rsp_id  output  clog2(NUM_REQ)  index of the requester that owns the result.
REQ-012 rsp_product  output  2*WIDTH  unsigned product A*B.
REQ-013 busy  output  1  high in MUL and RESP states.

Function
REQ-014 The FSM SHALL have three states: IDLE, MUL and RESP.
REQ-015 IDLE: if any req_valid is high, the block SHALL grant one requester by round-robin, starting at last_grant+1 and wrapping from NUM_REQ-1 to 0.
REQ-016 req_ready[g] SHALL be a combinational one-hot of the winner, only in IDLE; it SHALL be 0 in MUL and RESP.
REQ-017 On the grant edge the block SHALL capture req_a[g], req_b[g] and g; set last_grant=g; clear the accumulator; go to MUL.
REQ-018 MUL: iterative shift-add, one operand bit per cycle: if b_reg[cnt] is set, acc += a_reg<<cnt; cnt counts 0..WIDTH-1; after cnt=WIDTH-1 go to RESP.
REQ-019 The product SHALL be exact unsigned: 2*WIDTH bits, no truncation. Examples: 15*15=225, 0*x=0.
REQ-020 Latency: grant at cycle T, rsp_valid high from cycle T+WIDTH+1.
REQ-021 RESP: rsp_valid=1. rsp_product and rsp_id SHALL stay stable until rsp_ready is sampled high; on that edge go to IDLE.
REQ-022 No new grant while in RESP. The earliest next grant is the cycle after the response handshake. Peak throughput is one operation per WIDTH+2 cycles.
REQ-023 A requester may drop req_valid before its grant without error; arbitration uses only the current req_valid.
REQ-024 Operand changes after the grant SHALL NOT affect the in-flight result.
REQ-025 rsp_product and rsp_id SHALL keep their last values after the handshake until the next result loads.

Reset
REQ-026 While rst_n=0: state=IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0; cnt=0, acc=0.
REQ-027 last_grant SHALL reset to NUM_REQ-1, so requester 0 wins first.
REQ-028 Reset during MUL or RESP SHALL abandon the operation; no response is ever issued for it.

Configuration
REQ-029 Macro MULT_SHARE_ARB_FAST_EN.
- Defined: MUL is skipped; the product a_reg*b_reg is computed combinationally on the grant edge; RESP is entered directly; rsp_valid is high at T+1.
- Undefined: iterative behaviour per REQ-018 and REQ-020.
- The interface is identical in both builds.

Structure
REQ-030 A shared package mult_share_pkg SHALL hold the FSM state enum (IDLE, MUL, RESP) and the default parameter constants.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (req, last_grant in; one-hot grant and index out).

Verification
REQ-032 Only req0 valid, a=15, b=15, rsp_ready=1: req_ready[0] high at T; rsp_valid at T+5; product=225; id=0.
REQ-033 All four valid and held from reset: grant order 0,1,2,3,0. Each product is correct for its operand pair.
REQ-034 rsp_ready low for 10 cycles in RESP: rsp_valid, rsp_product and rsp_id stable; req_ready=0 throughout.
REQ-035 Operands a=0,b=7 give 0; a=9,b=1 give 9; a=8,b=12 give 96. Operands changed mid-MUL do not alter the result.
REQ-036 rst_n pulsed low at MUL cycle 2 with req2 in flight: all outputs 0 immediately; no response for req2; with req0 and req2 both valid, the next grant goes to req0.
REQ-037 MULT_SHARE_ARB_FAST_EN build, a=13, b=11: rsp_valid at T+1, product=143.
